// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect push buttons for gol.
// Define BTN_AUTOREPEAT_EN to emit repeat pulses while masked buttons are held.
module btn_conditioner #(
  parameter int          NUM_BTNS        = 3,
  parameter int          SW_WIDTH        = 3,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          REPEAT_CYCLES   = 16,
  parameter int unsigned REPEAT_MASK     = 3'b001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_n_in,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [NUM_BTNS-1:0] btn_pulse_n,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [SW_WIDTH-1:0] sw_out
);

  localparam int CNT_MAX =
    (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 1) ||
      (REPEAT_CYCLES < 1) || ((REPEAT_MASK >> NUM_BTNS) != 0))
  begin : g_bad_params
    $error("btn_conditioner: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0][NUM_BTNS-1:0] bsync_q, bsync_d;
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] ssync_q, ssync_d;
  logic [NUM_BTNS-1:0] s;
  logic [SW_WIDTH-1:0] ssw;

  logic [1:0]    st_q  [NUM_BTNS];
  logic [1:0]    st_d  [NUM_BTNS];
  logic [CW-1:0] cnt_q [NUM_BTNS];
  logic [CW-1:0] cnt_d [NUM_BTNS];

  logic [NUM_BTNS-1:0] pulse_n_q, pulse_n_d;
  logic [NUM_BTNS-1:0] level_q, level_d;
  logic [SW_WIDTH-1:0] sw_q, sw_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [NUM_BTNS-1:0] RPT_EN   = NUM_BTNS'(REPEAT_MASK);
  localparam logic [CW-1:0]       RPT_LAST = CW'(REPEAT_CYCLES);
  logic [CW-1:0] rpt_q [NUM_BTNS];
  logic [CW-1:0] rpt_d [NUM_BTNS];
`endif

  assign s   = bsync_q[SYNC_STAGES-1];
  assign ssw = ssync_q[SYNC_STAGES-1];

  // Shift raw inputs through the synchroniser chains.
  always_comb begin
    bsync_d = {bsync_q[SYNC_STAGES-2:0], btn_n_in};
    ssync_d = {ssync_q[SYNC_STAGES-2:0], sw_in};
  end

  // Per-button debounce FSM; a pulse fires only on acceptance of a press.
  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      pulse_n_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
      rpt_d[i]     = rpt_q[i];
`endif
      unique case (st_q[i])
        IDLE: begin
          if (!s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              st_d[i]      = HELD;
              pulse_n_d[i] = 1'b0;
            end else begin
              st_d[i]  = DEB_PRESS;
              cnt_d[i] = CW'(1);
            end
          end
        end
        DEB_PRESS: begin
          if (s[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CW'(1) == DEB_LAST) begin
            st_d[i]      = HELD;
            cnt_d[i]     = '0;
            pulse_n_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HELD: begin
          if (s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              st_d[i] = IDLE;
            end else begin
              st_d[i]  = DEB_RELEASE;
              cnt_d[i] = CW'(1);
            end
`ifdef BTN_AUTOREPEAT_EN
          end else if (RPT_EN[i]) begin
            if (rpt_q[i] + CW'(1) == RPT_LAST) begin
              pulse_n_d[i] = 1'b0;
              rpt_d[i]     = '0;
            end else begin
              rpt_d[i] = rpt_q[i] + CW'(1);
            end
`endif
          end
        end
        DEB_RELEASE: begin
          if (!s[i]) begin
            st_d[i]  = HELD;
            cnt_d[i] = '0;
          end else if (cnt_q[i] + CW'(1) == DEB_LAST) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
`ifdef BTN_AUTOREPEAT_EN
      if (st_d[i] == IDLE) rpt_d[i] = '0;
      if (st_d[i] == HELD && st_q[i] != HELD) rpt_d[i] = '0;
`endif
      level_d[i] = (st_d[i] == HELD) || (st_d[i] == DEB_RELEASE);
    end
  end

  // Capture switches once whenever any pulse asserts.
  always_comb begin
    sw_d = (&pulse_n_d) ? sw_q : ssw;
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bsync_q   <= '1;
      ssync_q   <= '0;
      pulse_n_q <= '1;
      level_q   <= '0;
      sw_q      <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q[i] <= '0;
`endif
      end
    end else begin
      bsync_q   <= bsync_d;
      ssync_q   <= ssync_d;
      pulse_n_q <= pulse_n_d;
      level_q   <= level_d;
      sw_q      <= sw_d;
      for (int i = 0; i < NUM_BTNS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
        rpt_q[i] <= rpt_d[i];
`endif
      end
    end
  end

  assign btn_pulse_n = pulse_n_q;
  assign btn_level   = level_q;
  assign sw_out      = sw_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: randomized and directed bench for btn_conditioner.
// Reference model treats debouncing as run-length counting of synced samples.
module tb_btn_conditioner;

  localparam int NB   = 3;
  localparam int SWW  = 3;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REP  = 16;
  localparam logic [NB-1:0] RMASK = 3'b001;

  logic clk = 1'b0;
  logic reset;
  logic [NB-1:0]  btn_n_in;
  logic [SWW-1:0] sw_in;
  logic [NB-1:0]  btn_pulse_n;
  logic [NB-1:0]  btn_level;
  logic [SWW-1:0] sw_out;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0]  bh [SYNC];
  logic [SWW-1:0] sh [SYNC];
  logic [NB-1:0]  m_lv, m_pn;
  logic [SWW-1:0] m_sw;
  int             m_run [NB];
`ifdef BTN_AUTOREPEAT_EN
  int             m_age [NB];
`endif

  btn_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n_in    (btn_n_in),
    .sw_in       (sw_in),
    .btn_pulse_n (btn_pulse_n),
    .btn_level   (btn_level),
    .sw_out      (sw_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) begin
      bh[k] = '1;
      sh[k] = '0;
    end
    m_lv = '0;
    m_pn = '1;
    m_sw = '0;
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
      m_age[i] = 0;
`endif
    end
  endtask

  // Level flips after DEB consecutive synced samples disagreeing with it.
  task automatic model_edge();
    logic [NB-1:0]  s;
    logic [SWW-1:0] ss;
    logic [NB-1:0]  pn;
    logic           want;
    s  = bh[SYNC-1];
    ss = sh[SYNC-1];
    for (int k = SYNC - 1; k > 0; k--) begin
      bh[k] = bh[k-1];
      sh[k] = sh[k-1];
    end
    bh[0] = btn_n_in;
    sh[0] = sw_in;
    pn = '1;
    for (int i = 0; i < NB; i++) begin
      want = !s[i];
      if (want != m_lv[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lv[i]  = want;
          m_run[i] = 0;
          if (want) pn[i] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          m_age[i] = 0;
`endif
        end
      end else begin
`ifdef BTN_AUTOREPEAT_EN
        if (m_lv[i] && RMASK[i]) begin
          if (m_run[i] != 0) begin
            m_age[i] = 0;
          end else begin
            m_age[i]++;
            if (m_age[i] == REP) begin
              pn[i]    = 1'b0;
              m_age[i] = 0;
            end
          end
        end
`endif
        m_run[i] = 0;
      end
    end
    m_pn = pn;
    if (pn != '1) m_sw = ss;
  endtask

  task automatic cyc(input logic [NB-1:0] b, input logic [SWW-1:0] sw);
    btn_n_in = b;
    sw_in    = sw;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    btn_n_in = '1;
    sw_in    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({btn_pulse_n, btn_level, sw_out} !== 9'b111_000_000) begin
      errors++;
      $display("FAIL reset_vals: got pn=%b lv=%b sw=%b want 111 000 000",
               btn_pulse_n, btn_level, sw_out);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(3'b111, 3'b000);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int np = 0;
    for (int k = 0; k < 30; k++) begin
      cyc((k < 20) ? 3'b101 : 3'b111, 3'b010);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL clean c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
      if (!btn_pulse_n[1]) begin
        np++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (np !== 1 || first !== 5) begin
      errors++;
      $display("FAIL clean_timing: got %0d pulses first at %0d want 1 at 5",
               np, first);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    int np = 0;
    logic seen_lv = 1'b0;
    for (int k = 0; k < 23; k++) begin
      cyc((k < 13 && k != 2) ? 3'b110 : 3'b111, 3'b000);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL bounce c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
      if (!btn_pulse_n[0]) begin
        np++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (np !== 1 || first !== 8) begin
      errors++;
      $display("FAIL bounce_timing: got %0d pulses first at %0d want 1 at 8",
               np, first);
    end
    np = 0;
    for (int k = 0; k < 13; k++) begin
      cyc((k < 3) ? 3'b110 : 3'b111, 3'b000);
      if (!btn_pulse_n[0]) np++;
      if (btn_level[0]) seen_lv = 1'b1;
    end
    checks++;
    if (np !== 0 || seen_lv !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got %0d pulses level_seen=%b want 0 and 0",
               np, seen_lv);
    end
  endtask

  task automatic test_switch();
    logic [SWW-1:0] cap = '0;
    for (int k = 0; k < 3; k++) cyc(3'b111, 3'b011);
    for (int k = 0; k < 10; k++) begin
      cyc(3'b101, 3'b011);
      if (!btn_pulse_n[1]) cap = sw_out;
    end
    checks++;
    if (cap !== 3'b011) begin
      errors++;
      $display("FAIL sw_capture: got %b want 011", cap);
    end
    for (int k = 0; k < 12; k++) cyc(3'b111, 3'b100);
    checks++;
    if (sw_out !== 3'b011) begin
      errors++;
      $display("FAIL sw_hold: got %b want 011", sw_out);
    end
    checks++;
    if (m_sw !== sw_out) begin
      errors++;
      $display("FAIL sw_model: got %b want %b", sw_out, m_sw);
    end
  endtask

  task automatic test_release_bounce();
    int np = 0;
    int fall = -1;
    logic dropped = 1'b0;
    for (int k = 0; k < 10; k++) cyc(3'b011, 3'b000);
    for (int k = 0; k < 10; k++) begin
      cyc((k < 2) ? 3'b111 : 3'b011, 3'b000);
      if (!btn_pulse_n[2]) np++;
      if (!btn_level[2]) dropped = 1'b1;
    end
    checks++;
    if (np !== 0 || dropped !== 1'b0) begin
      errors++;
      $display("FAIL rel_bounce: got %0d pulses dropped=%b want 0 and 0",
               np, dropped);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(3'b111, 3'b000);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL release c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
      if (!btn_level[2] && fall < 0) fall = k;
    end
    checks++;
    if (fall !== 5) begin
      errors++;
      $display("FAIL release_timing: got level fall at %0d want 5", fall);
    end
  endtask

  task automatic test_simultaneous_reset();
    logic [NB-1:0] pv = '1;
    int first = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(3'b100, 3'b101);
      if (k == 5) pv = btn_pulse_n;
    end
    checks++;
    if (pv !== 3'b100) begin
      errors++;
      $display("FAIL simul_pulse: got %b want 100", pv);
    end
    for (int k = 0; k < 10; k++) cyc(3'b111, 3'b101);
    for (int k = 0; k < 3; k++) cyc(3'b011, 3'b000);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({btn_pulse_n, btn_level, sw_out} !== 9'b111_000_000) begin
      errors++;
      $display("FAIL async_reset: got %b %b %b want 111 000 000",
               btn_pulse_n, btn_level, sw_out);
    end
    cyc(3'b011, 3'b000);
    cyc(3'b011, 3'b000);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(3'b011, 3'b000);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL post_reset c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
      if (!btn_pulse_n[2] && first < 0) first = k;
    end
    checks++;
    if (first !== 5) begin
      errors++;
      $display("FAIL repulse_timing: got %0d want 5", first);
    end
    for (int k = 0; k < 10; k++) cyc(3'b111, 3'b000);
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int np0 = 0;
    int np1 = 0;
    for (int k = 0; k < 70; k++) begin
      cyc((k < 60) ? 3'b110 : 3'b111, 3'b001);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL rpt_run c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
      if (!btn_pulse_n[0]) np0++;
    end
    for (int k = 0; k < 70; k++) begin
      cyc((k < 60) ? 3'b101 : 3'b111, 3'b010);
      if (!btn_pulse_n[1]) np1++;
    end
    checks++;
    if (np0 !== 4 || np1 !== 1) begin
      errors++;
      $display("FAIL rpt_count: got run=%0d load=%0d want 4 and 1", np0, np1);
    end
  endtask
`endif

  task automatic test_random();
    logic [NB-1:0]  b  = '1;
    logic [SWW-1:0] sw = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
      if ($urandom_range(0, 7) == 0) sw = SWW'($urandom);
      cyc(b, sw);
      checks++;
      if ({btn_pulse_n, btn_level, sw_out} !== {m_pn, m_lv, m_sw}) begin
        errors++;
        $display("FAIL random c%0d: got %b %b %b want %b %b %b", k,
                 btn_pulse_n, btn_level, sw_out, m_pn, m_lv, m_sw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch();
    test_release_bounce();
    test_simultaneous_reset();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end stage feeding the gol core.
- Synchronises, debounces and edge-detects the raw active-low push buttons (run, load, reset).
- Synchronises the slide switches for the load path. Each accepted press becomes exactly one active-low, one-clock pulse on the gol button inputs.
- The switch value is captured coincident with that pulse, so gol sees stable data_in on the load cycle.

Parameters:
- NUM_BTNS, 3, number of buttons; index 0=run, 1=load, 2=reset.
- SW_WIDTH, 3, switch width; equals gol WIDTH-2.
- SYNC_STAGES, 2, synchroniser flops per input; must be ≥2.
- DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a press or release; must be ≥1. Board builds use ~500000.
- REPEAT_CYCLES, 16, auto-repeat period in clocks; used only with the optional feature.
- REPEAT_MASK, 3'b001, per-button auto-repeat enable; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- btn_n_in  in  NUM_BTNS  raw buttons, active-low, asynchronous, bouncy.
- sw_in  in  SW_WIDTH  raw slide switches, asynchronous.
- btn_pulse_n  out  NUM_BTNS  one-cycle active-low press pulse per button; drives gol run_btn/load_btn/reset_btn.
- btn_level  out  NUM_BTNS  debounced pressed level, active-high.
- sw_out  out  SW_WIDTH  synchronised switches captured at the most recent pulse; drives gol data_in.

Behaviour:
- Reset (async assert, deassert synchronous to clk):
  - button sync flops = 1; switch sync flops = 0.
  - every button FSM goes to IDLE; counters = 0.
  - btn_pulse_n = all 1; btn_level = 0; sw_out = 0.
- Synchroniser: s[i] is btn_n_in[i] after SYNC_STAGES flops; similarly ssw for sw_in.
- Per-button FSM, independent per index; counter width clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES)+1):
  - IDLE: s=0 → DEB_PRESS, cnt=1; if DEBOUNCE_CYCLES=1 go straight to HELD and pulse.
  - DEB_PRESS: s=1 → IDLE (bounce rejected, no pulse). s=0 and cnt+1=DEBOUNCE_CYCLES → HELD and assert pulse. Otherwise cnt++.
  - HELD: s=1 → DEB_RELEASE, cnt=1. Otherwise stay.
  - DEB_RELEASE: s=0 → HELD (no new pulse). s=1 for DEBOUNCE_CYCLES consecutive samples → IDLE. No pulse on release.
- btn_level[i] = 1 in HELD and DEB_RELEASE, else 0. It is registered and updates on the same edge as the state.
- btn_pulse_n[i] is registered and low for exactly one clock, on the edge that enters HELD from DEB_PRESS.
- Latency: raw input first sampled low at posedge P and held low → pulse low during the cycle after posedge P+SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: after P+5).
- sw_out loads ssw on the same edge any pulse asserts, so it is valid while the pulse is low and holds until the next pulse.
- Simultaneous presses: multiple pulses may assert in the same cycle; sw_out is captured once.
- Input changing during DEB_* states only restarts or aborts that button's count; other buttons are unaffected.
- Reset mid-debounce or mid-hold: returns to IDLE. A button still held after reset deasserts is treated as a fresh press, giving a new pulse after full latency.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: in HELD with REPEAT_MASK[i]=1, a repeat counter starts at entry to HELD. Every REPEAT_CYCLES clocks while s=0, another one-cycle pulse is emitted and sw_out is recaptured. The counter clears on leaving HELD and is frozen during DEB_RELEASE; returning to HELD restarts it at 0.
- Undefined: REPEAT_* parameters ignored; exactly one pulse per accepted press; no repeat logic synthesised.

Test Plan:
- Clean press: btn_n_in[1] low at posedge P, held 20 clocks → btn_pulse_n[1] low for exactly one cycle after P+5; btn_level[1] rises on the same edge; no second pulse.
- Bounce: btn_n_in[0] low 2 clocks, high 1, low 10 → exactly one pulse, timed from the final falling sample; a 3-clock glitch alone gives no pulse and btn_level stays 0.
- Switch capture: sw_in=3'b011, press load → sw_out=3'b011 on the pulse cycle. Change sw_in to 3'b100 with no press → sw_out stays 3'b011.
- Release bounce: while HELD, raise input 2 clocks then lower → stays HELD, no pulse; full release for 4+ clocks → IDLE, btn_level 0 after SYNC_STAGES+3 edges.
- Simultaneous plus reset: press run and load on the same edge → both pulses in the same cycle. Assert reset during DEB_PRESS of reset-button → outputs at reset values immediately; the held button re-pulses after full latency post-deassert.
- BTN_AUTOREPEAT_EN: hold run 60 clocks with defaults → pulses at entry and every 16 clocks thereafter (4 total); load held the same → 1 pulse.
